// File: rtl/signal_monitor.sv
// signal_monitor: independent watchdog on the traffic-signal lamp lines.
// Decodes the four lamp inputs every clock, enforces the A/B green sequence,
// times each green phase against MIN_GREEN/MAX_GREEN and latches the first fault.
module signal_monitor #(
  parameter int unsigned NBITS     = 32,
  parameter int unsigned MIN_GREEN = 32'h1C9C380,
  parameter int unsigned MAX_GREEN = 32'h3938700
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Ago,
  input  logic             Astop,
  input  logic             Bgo,
  input  logic             Bstop,
  output logic [1:0]       cur_phase,
  output logic [NBITS-1:0] phase_len,
  output logic             phase_done,
  output logic [15:0]      phase_total,
  output logic             fault,
  output logic [2:0]       fault_code
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_A     = 2'd1;
  localparam logic [1:0] ST_B     = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_CONFLICT = 3'd1;
  localparam logic [2:0] FC_SHORT    = 3'd2;
  localparam logic [2:0] FC_LONG     = 3'd3;
  localparam logic [2:0] FC_SEQ      = 3'd4;

  localparam logic [NBITS-1:0] MIN_G = NBITS'(MIN_GREEN);
  localparam logic [NBITS-1:0] MAX_G = NBITS'(MAX_GREEN);
  localparam logic [NBITS-1:0] ONE   = NBITS'(1);

  logic [1:0]       state_q, state_d;
  logic [NBITS-1:0] cnt_q, cnt_d;
  logic [NBITS-1:0] len_q, len_d;
  logic             done_q, done_d;
  logic [15:0]      total_q, total_d;
  logic             fault_q, fault_d;
  logic [2:0]       code_q, code_d;

  logic [3:0] lamps;
  logic       is_off, is_ag, is_bg;
  logic       own_green, other_green;

  // Lamp pattern decode; anything but OFF/AG/BG is a conflict.
  always_comb begin
    lamps  = {Ago, Astop, Bgo, Bstop};
    is_off = (lamps == 4'b0000);
    is_ag  = (lamps == 4'b1001);
    is_bg  = (lamps == 4'b0110);
    own_green   = (state_q == ST_A) ? is_ag : is_bg;
    other_green = (state_q == ST_A) ? is_bg : is_ag;
  end

  // Next-state and output logic for the phase tracker.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    done_d  = 1'b0;
    total_d = total_q;
    fault_d = fault_q;
    code_d  = code_q;
    case (state_q)
      ST_IDLE: begin
        if (is_ag) begin
          state_d = ST_A;
          cnt_d   = ONE;
        end else if (is_bg) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
          code_d  = FC_SEQ;
        end else if (!is_off) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
          code_d  = FC_CONFLICT;
        end
      end
      ST_A, ST_B: begin
        if (own_green) begin
          if (cnt_q == MAX_G) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
            code_d  = FC_LONG;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end else if (other_green) begin
          // Phase handover: report the completed phase even if it was short.
          len_d   = cnt_q;
          done_d  = 1'b1;
          total_d = total_q + 16'd1;
          if (cnt_q < MIN_G) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
            code_d  = FC_SHORT;
          end else begin
            state_d = (state_q == ST_A) ? ST_B : ST_A;
            cnt_d   = ONE;
          end
        end else if (is_off) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
          code_d  = FC_SEQ;
        end else begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
          code_d  = FC_CONFLICT;
        end
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      total_q <= '0;
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      done_q  <= done_d;
      total_q <= total_d;
      fault_q <= fault_d;
      code_q  <= code_d;
    end
  end

  assign cur_phase   = state_q;
  assign phase_len   = len_q;
  assign phase_done  = done_q;
  assign phase_total = total_q;
  assign fault       = fault_q;
  assign fault_code  = code_q;

endmodule
